// File: rtl/sweep_pkg.sv
// Shared definitions for the servo max-power sweep controller:
// state codes, the sample comparison slice and a width helper.
package sweep_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 4'd0,
      ST_MOVE    = 4'd1,
      ST_SETTLE  = 4'd2,
      ST_REQ     = 4'd3,
      ST_WAIT    = 4'd4,
      ST_CMP     = 4'd5,
      ST_PARK    = 4'd6,
      ST_PSETTLE = 4'd7,
      ST_DONE    = 4'd8
   } state_t;

   // Bits of a sample that take part in comparisons; the low lsb bits are noise.
   function automatic logic [31:0] cmp_slice(input logic [31:0] v, input int lsb);
      return v >> lsb;
   endfunction

   // Ceiling log2, used to size down-counters.
   function automatic int clog2(input longint unsigned n);
      int r;
      r = 0;
      while ((64'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/sweep_controller_settle_timer.sv
// Settling down-counter shared by the per-position settle and the final park
// settle. A load pulse arms it; expired is high on the last of SETTLE_CYCLES
// cycles following the load.
module settle_timer
   import sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam int CNT_W = (clog2(SETTLE_CYCLES) < 1) ? 1 : clog2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Count down from SETTLE_CYCLES-1 to zero after each load, then hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/sweep_controller.sv
// Max-power sweep sequencer: steps the servo over POS_MIN..POS_MAX, settles,
// takes one ADC sample per position, tracks the maximum, then parks the servo
// at the best position and reports it.
// Optional build macro SWEEP_ADC_TIMEOUT_EN adds an ADC wait timeout with a
// sticky err flag; without it WAIT blocks until adc_valid and err is tied low.
module sweep_controller
   import sweep_pkg::*;
#(
   parameter int ADC_W          = 10,
   parameter int CMP_LSB        = 4,
   parameter int POS_W          = 8,
   parameter int POS_MIN        = 0,
   parameter int POS_MAX        = 180,
   parameter int SETTLE_CYCLES  = 1000000,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ADC_W-1:0] adc_data,
   input  logic             adc_valid,
   output logic             adc_req,
   output logic [POS_W-1:0] servo_pos,
   output logic [POS_W-1:0] best_pos,
   output logic [ADC_W-1:0] best_val,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);

   state_t           state, next_state;
   logic [POS_W-1:0] cur_pos, run_pos;
   logic [ADC_W-1:0] run_val, sample;
   logic             first_flag;
   logic             settle_load, settle_expired;
   logic             update;
   logic             adc_req_nxt, busy_nxt, done_nxt;
   logic             wait_expired;
   logic             keep_result;

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (settle_load),
      .expired(settle_expired)
   );

`ifdef SWEEP_ADC_TIMEOUT_EN
   localparam int TO_W = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] wait_cnt;

   assign wait_expired = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign keep_result  = ~err;

   // Count cycles spent in WAIT; restarts every time WAIT is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state != ST_WAIT) begin
         wait_cnt <= '0;
      end else if (!adc_valid && !wait_expired) begin
         wait_cnt <= wait_cnt + TO_W'(1);
      end
   end

   // Sticky timeout flag: set on an expired ADC wait, cleared by the next accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (state == ST_IDLE && start) begin
         err <= 1'b0;
      end else if (state == ST_WAIT && !adc_valid && wait_expired) begin
         err <= 1'b1;
      end
   end
`else
   assign wait_expired = 1'b0;
   assign keep_result  = 1'b1;
   assign err          = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of block order.
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch is inferred.
      next_state = state;
      unique case (state)
         ST_IDLE:    if (start) next_state = ST_MOVE;
         ST_MOVE:    next_state = ST_SETTLE;
         ST_SETTLE:  if (settle_expired) next_state = ST_REQ;
         ST_REQ:     next_state = ST_WAIT;
         ST_WAIT: begin
            if (adc_valid)         next_state = ST_CMP;
            else if (wait_expired) next_state = ST_PARK;
         end
         ST_CMP:     next_state = (cur_pos == P_MAX) ? ST_PARK : ST_MOVE;
         ST_PARK:    next_state = ST_PSETTLE;
         ST_PSETTLE: if (settle_expired) next_state = ST_DONE;
         ST_DONE:    next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Output decode: timer arming, compare decision and next values of the registered strobes.
   always_comb begin
      settle_load = (state == ST_MOVE) || (state == ST_PARK);
      update      = (state == ST_CMP) &&
                    (!first_flag ||
                     (cmp_slice(32'(sample), CMP_LSB) > cmp_slice(32'(run_val), CMP_LSB)));
      adc_req_nxt = (next_state == ST_REQ);
      busy_nxt    = (next_state != ST_IDLE);
      done_nxt    = (next_state == ST_DONE);
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adc_req    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         servo_pos  <= P_MIN;
         best_pos   <= P_MIN;
         best_val   <= '0;
         cur_pos    <= P_MIN;
         run_pos    <= P_MIN;
         run_val    <= '0;
         sample     <= '0;
         first_flag <= 1'b0;
      end else begin
         adc_req <= adc_req_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         unique case (state)
            ST_IDLE: begin
               // A new sweep starts from scratch; nothing of the last run is carried over.
               if (start) begin
                  cur_pos    <= P_MIN;
                  run_pos    <= P_MIN;
                  run_val    <= '0;
                  first_flag <= 1'b0;
               end
            end
            ST_MOVE: servo_pos <= cur_pos;
            ST_WAIT: if (adc_valid) sample <= adc_data;
            ST_CMP: begin
               // Strict greater-than on the masked slice: ties keep the lower position.
               if (update) begin
                  run_val <= sample;
                  run_pos <= cur_pos;
               end
               first_flag <= 1'b1;
               if (cur_pos != P_MAX) cur_pos <= cur_pos + POS_W'(1);
            end
            ST_PARK: servo_pos <= run_pos;
            ST_PSETTLE: begin
               // Result becomes visible together with the done pulse.
               if (settle_expired && keep_result) begin
                  best_pos <= run_pos;
                  best_val <= run_val;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
Sequences one max-power sweep of the tracker servo. For each position it moves the servo, waits for settling, requests one ADC conversion and compares the sample against the running maximum. After the last position it parks the servo at the best position found and reports it. It sits between the top-level start button/debouncer, the ADC interface and the servo PWM generator.

Parameters:
ADC_W, 10, ADC sample width
CMP_LSB, 4, number of low sample bits ignored in comparisons (compare [ADC_W-1:CMP_LSB])
POS_W, 8, servo position index width
POS_MIN, 0, first sweep position
POS_MAX, 180, last sweep position (inclusive); must satisfy POS_MIN <= POS_MAX < 2**POS_W
SETTLE_CYCLES, 1000000, clk cycles to wait after each servo move (10 ms at 100 MHz); must be >= 1
TIMEOUT_CYCLES, 4096, ADC wait limit; used only with SWEEP_ADC_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse; ignored unless idle
adc_data  in  ADC_W  conversion result, valid only when adc_valid=1
adc_valid  in  1  one-cycle strobe marking adc_data valid
adc_req  out  1  one-cycle conversion request
servo_pos  out  POS_W  commanded servo position
best_pos  out  POS_W  position of the maximum sample from the last completed sweep
best_val  out  ADC_W  full-width maximum sample from the last completed sweep
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at sweep completion
err  out  1  sticky ADC timeout flag (tied 0 when the feature is out)

Behaviour:
- Reset (async, rst_n=0): state IDLE; adc_req=0, servo_pos=POS_MIN, best_pos=POS_MIN, best_val=0, busy=0, done=0, err=0; all counters cleared. Reset mid-sweep abandons the sweep immediately. No partial result is kept.
- States: IDLE, MOVE, SETTLE, REQ, WAIT, CMP, PARK, PSETTLE, DONE.
- IDLE: on start=1 go to MOVE. Load cur_pos=POS_MIN, clear first_flag. Clear err (feature in). Load the settle counter.
- MOVE (1 cycle): servo_pos<=cur_pos; go to SETTLE.
- SETTLE: count down exactly SETTLE_CYCLES cycles, then go to REQ.
- REQ (1 cycle): adc_req=1; go to WAIT.
- WAIT: hold until adc_valid=1, then latch adc_data into sample and go to CMP. adc_valid in any other state is ignored.
- CMP (1 cycle): update when the first sample of the sweep arrives (first_flag=0), or when sample[ADC_W-1:CMP_LSB] > run_val[ADC_W-1:CMP_LSB] (strict greater-than).
  - On update: run_val<=sample, run_pos<=cur_pos.
  - Ties keep the earlier, lower position.
  - Then set first_flag.
  - If cur_pos==POS_MAX go to PARK; else cur_pos<=cur_pos+1 and go to MOVE.
  - No wrap-around: the increment never executes at POS_MAX.
- PARK (1 cycle): servo_pos<=run_pos; reload the settle counter; go to PSETTLE.
- PSETTLE: wait SETTLE_CYCLES, then go to DONE.
- DONE (1 cycle): best_pos<=run_pos, best_val<=run_val, done=1; go to IDLE.
- best_pos/best_val change only in DONE. They hold the previous result throughout a new sweep.
- busy=1 in every state except IDLE.
- start while busy is ignored, with no queueing.
- POS_MIN==POS_MAX gives one sample; best_pos=POS_MIN.
- Sweep latency with N=POS_MAX-POS_MIN+1 and ADC response delay D (cycles from adc_req to adc_valid):
  - per position: 1+SETTLE_CYCLES+1+D+1 cycles
  - plus 1+SETTLE_CYCLES+1 for park and done.
- All outputs are registered.

Optional Feature:
SWEEP_ADC_TIMEOUT_EN
- Defined: WAIT counts cycles. If TIMEOUT_CYCLES elapse without adc_valid, set err=1 and go to PARK using the current run_pos (POS_MIN if no sample was taken). best_pos/best_val are not updated; DONE still pulses done. err stays set until the next accepted start or reset.
- Undefined: WAIT waits indefinitely; err tied 0; no timeout counter is synthesised.

Decomposition:
- Package sweep_pkg: state enum encoding (localparam codes, 4 bits), a function returning the compare slice, and a clog2 helper for counter widths.
- One sub-module: settle_timer. Inputs load/clk/rst_n, parameter SETTLE_CYCLES, output expired. It is reused for both SETTLE and PSETTLE.
- The comparison stays inline in CMP.

Test Plan:
1. POS_MIN=0, POS_MAX=4, SETTLE=3; ADC returns 0x100,0x200,0x3F0,0x150,0x010 -> best_pos=2, best_val=0x3F0, final servo_pos=2, exactly 5 adc_req pulses, done one cycle.
2. Tie below mask: samples 0x205,0x20F,0x200 -> best_pos=0, best_val=0x205 (0x20F not strictly greater in [9:4]).
3. All samples 0 -> first-sample rule gives best_pos=POS_MIN, best_val=0.
4. start pulsed during SETTLE and during WAIT -> ignored; only one done pulse; latency matches the formula with D=2.
5. rst_n low during WAIT at position 3 -> outputs at reset values the same cycle; the next start sweeps from POS_MIN and the previous best is not kept.
6. SWEEP_ADC_TIMEOUT_EN, TIMEOUT=8, adc_valid withheld at position 1 -> err=1 after 8 WAIT cycles, servo parks at 0, done pulses, best_pos/best_val unchanged; the next start clears err.
